// File: rtl/weighted_mean_seq_pkg.sv
// Shared types and sizing helpers for the weighted-mean sequencer.
package weighted_mean_pkg;

    // Controller phases: wait for a vector, accumulate lanes, divide, hold result.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Numerator width: full product plus headroom for summing n_input products.
    function automatic int acc_w(input int n_input, input int size);
        return 2 * size + $clog2(n_input);
    endfunction

    // Bit offset of a lane inside a flattened lane vector.
    function automatic int lane_lsb(input int lane, input int size);
        return lane * size;
    endfunction

endpackage

// File: rtl/weighted_mean_seq_if.sv
// Vector-in / result-out handshake bundle for the weighted-mean sequencer.
interface weighted_mean_seq_if
    import weighted_mean_pkg::*;
#(
    parameter int N_INPUT = 4,
    parameter int SIZE    = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [N_INPUT*SIZE-1:0]   in;
    logic [N_INPUT*SIZE-1:0]   weight;
    logic                      out_valid;
    logic                      out_ready;
    logic [SIZE-1:0]           mean;
    logic                      div_zero;
    logic                      busy;

    // Upstream/downstream side: offers vectors, consumes results.
    modport master (
        output in_valid, in, weight, out_ready,
        input  in_ready, out_valid, mean, div_zero, busy
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in, weight, out_ready,
        output in_ready, out_valid, mean, div_zero, busy
    );
endinterface

// File: rtl/wm_serial_div.sv
// Serial restoring divider: one quotient bit per step, MSB first.
// start loads operands; each step consumes one dividend bit; done rises
// after the last step and stays high until the next start.
module wm_serial_div
    import weighted_mean_pkg::*;
#(
    parameter int DIVIDEND_W = 66,
    parameter int DIVISOR_W  = 34
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  step,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic                  done
);
    localparam int CNT_W = $clog2(DIVIDEND_W);

    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  done_q, done_d;

    // Partial remainder with the next dividend bit shifted in; one bit wider
    // than the divisor because it can reach just under twice the divisor.
    logic [DIVISOR_W:0]    rem_shift;
    logic                  fits;

    assign rem_shift = {rem_q, dvd_q[DIVIDEND_W-1]};
    assign fits      = (rem_shift >= {1'b0, dvs_q});

    // Load on start, otherwise perform one restoring step per step pulse.
    always_comb begin
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = done_q;
        if (start) begin
            dvd_d     = dividend;
            dvs_d     = divisor;
            rem_d     = '0;
            quo_d     = '0;
            bit_cnt_d = CNT_W'(DIVIDEND_W - 1);
            done_d    = 1'b0;
        end else if (step && !done_q) begin
            // When it fits the true difference is below the divisor, so the
            // narrow subtraction is exact.
            rem_d = fits ? (rem_shift[DIVISOR_W-1:0] - dvs_q) : rem_shift[DIVISOR_W-1:0];
            quo_d = {quo_q[DIVIDEND_W-2:0], fits};
            dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
            if (bit_cnt_q == '0) begin
                done_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q - 1'b1;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/weighted_mean_seq.sv
// Weighted-mean sequencer: one shared multiplier walks the lanes to build
// sum(in*weight) and sum(weight), then a serial divider forms the truncated
// quotient, which is held on a valid/ready output until taken.
module weighted_mean_seq
    import weighted_mean_pkg::*;
#(
    parameter int N_INPUT = 4,
    parameter int SIZE    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    weighted_mean_seq_if.slave  bus
);
    localparam int ACC_W  = acc_w(N_INPUT, SIZE);
    localparam int DEN_W  = SIZE + $clog2(N_INPUT);
    localparam int CNT_W  = $clog2(N_INPUT);
    localparam int PROD_W = 2 * SIZE;

    state_e                  state_q, state_d;
    logic [N_INPUT*SIZE-1:0] in_q, in_d;
    logic [N_INPUT*SIZE-1:0] weight_q, weight_d;
    logic [ACC_W-1:0]        num_q, num_d;
    logic [DEN_W-1:0]        den_q, den_d;
    logic [CNT_W-1:0]        lane_cnt_q, lane_cnt_d;
    logic [SIZE-1:0]         mean_q, mean_d;
    logic                    div_zero_q, div_zero_d;
    logic                    out_valid_q, out_valid_d;

    logic [SIZE-1:0]         lane_in;
    logic [SIZE-1:0]         lane_w;
    logic [PROD_W-1:0]       prod;
    logic [ACC_W-1:0]        num_sum;
    logic [DEN_W-1:0]        den_sum;
    logic                    last_lane;

    logic                    div_start;
    logic                    div_step;
    logic                    div_done;
    logic [ACC_W-1:0]        quotient;

    // The mean never exceeds the largest sample, so the upper quotient bits
    // are zero; a non-zero upper part (or a zero divisor) saturates to all-ones.
    function automatic logic [SIZE-1:0] saturate_mean(input logic [ACC_W-1:0] q,
                                                      input logic den_is_zero);
        if (den_is_zero || ((q >> SIZE) != '0)) begin
            return '1;
        end
        return q[SIZE-1:0];
    endfunction

    assign lane_in   = in_q[lane_lsb(int'(lane_cnt_q), SIZE) +: SIZE];
    assign lane_w    = weight_q[lane_lsb(int'(lane_cnt_q), SIZE) +: SIZE];
    assign prod      = PROD_W'(lane_in) * PROD_W'(lane_w);
    assign num_sum   = num_q + ACC_W'(prod);
    assign den_sum   = den_q + DEN_W'(lane_w);
    assign last_lane = (lane_cnt_q == CNT_W'(N_INPUT - 1));

    // Next-state and datapath control; enable gates work, not the output transfer.
    always_comb begin
        state_d     = state_q;
        in_d        = in_q;
        weight_d    = weight_q;
        num_d       = num_q;
        den_d       = den_q;
        lane_cnt_d  = lane_cnt_q;
        mean_d      = mean_q;
        div_zero_d  = div_zero_q;
        out_valid_d = out_valid_q;
        div_start   = 1'b0;
        div_step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && enable) begin
                    in_d       = bus.in;
                    weight_d   = bus.weight;
                    num_d      = '0;
                    den_d      = '0;
                    lane_cnt_d = '0;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                if (enable) begin
                    num_d      = num_sum;
                    den_d      = den_sum;
                    lane_cnt_d = lane_cnt_q + 1'b1;
                    if (last_lane) begin
                        // The divider loads the final sums on the same edge.
                        lane_cnt_d = '0;
                        div_start  = 1'b1;
                        state_d    = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                if (enable) begin
                    if (den_q == '0) begin
                        mean_d      = saturate_mean(quotient, 1'b1);
                        div_zero_d  = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (div_done) begin
                        mean_d      = saturate_mean(quotient, 1'b0);
                        div_zero_d  = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        div_step = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_q        <= '0;
            weight_q    <= '0;
            num_q       <= '0;
            den_q       <= '0;
            lane_cnt_q  <= '0;
            mean_q      <= '0;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_q        <= in_d;
            weight_q    <= weight_d;
            num_q       <= num_d;
            den_q       <= den_d;
            lane_cnt_q  <= lane_cnt_d;
            mean_q      <= mean_d;
            div_zero_q  <= div_zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    wm_serial_div #(
        .DIVIDEND_W (ACC_W),
        .DIVISOR_W  (DEN_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .step     (div_step),
        .dividend (num_sum),
        .divisor  (den_sum),
        .quotient (quotient),
        .done     (div_done)
    );

    assign bus.in_ready  = (state_q == IDLE) && enable;
    assign bus.out_valid = out_valid_q;
    assign bus.mean      = mean_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_weighted_mean_seq.sv
// Bench for weighted_mean_seq: directed vectors with literal expectations plus
// a randomized phase, all checked every cycle against a behavioural model.
module tb_weighted_mean_seq;
    localparam int N     = 4;
    localparam int S     = 32;
    localparam int ACC_W = 2 * S + 2;
    localparam int LAT   = N + ACC_W + 1;
    localparam int LAT0  = N + 1;

    logic clk;
    logic reset;
    logic enable;

    weighted_mean_seq_if #(.N_INPUT(N), .SIZE(S)) bus ();

    weighted_mean_seq #(.N_INPUT(N), .SIZE(S)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    int cyc = 0;
    int total = 0;
    int bad = 0;

    // Control knobs written only by the main sequence.
    logic        rand_on = 1'b0;
    logic        dir_enable = 1'b1;
    logic        dir_out_ready = 1'b1;
    logic        chk_on = 1'b0;
    logic        lit_armed = 1'b0;
    logic [31:0] lit_mean = '0;
    logic        lit_dz = 1'b0;
    int          lit_lat = 0;

    // Behavioural model state.
    logic        m_busy = 1'b0;
    logic        m_valid = 1'b0;
    int          m_left = 0;
    logic [31:0] m_mean = '0;
    logic        m_dz = 1'b0;
    int          m_t_acc = 0;
    logic        m_rst_seen = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    // mean = floor(sum(in*w)/sum(w)), all-ones when sum(w)==0.
    function automatic logic [31:0] ref_mean(input logic [127:0] iv, input logic [127:0] wv);
        logic [ACC_W-1:0] num;
        logic [ACC_W-1:0] den;
        logic [ACC_W-1:0] q;
        num = '0;
        den = '0;
        for (int i = 0; i < N; i++) begin
            num += ACC_W'(iv[i*S +: S]) * ACC_W'(wv[i*S +: S]);
            den += ACC_W'(wv[i*S +: S]);
        end
        if (den == '0) return 32'hFFFF_FFFF;
        q = num / den;
        return 32'(q);
    endfunction

    // Model: accept when idle and enabled, count enabled work cycles, hold until taken.
    always @(posedge clk) begin
        if (reset) begin
            m_busy     <= 1'b0;
            m_valid    <= 1'b0;
            m_left     <= 0;
            m_rst_seen <= 1'b1;
        end else begin
            m_rst_seen <= 1'b0;
            if (m_valid && bus.out_ready) begin
                m_valid <= 1'b0;
                m_busy  <= 1'b0;
            end else if (!m_busy && enable && bus.in_valid) begin
                m_busy  <= 1'b1;
                m_left  <= (bus.weight == '0) ? LAT0 : LAT;
                m_mean  <= ref_mean(bus.in, bus.weight);
                m_dz    <= (bus.weight == '0);
                m_t_acc <= cyc + 1;
            end else if (m_busy && !m_valid && enable) begin
                if (m_left == 1) m_valid <= 1'b1;
                m_left <= m_left - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Single compare process, sampling on the falling edge.
    logic prev_valid = 1'b0;
    logic pins_done = 1'b0;
    always @(negedge clk) begin
        if (chk_on) begin
            if (!pins_done) begin
                chk("model_eq_w", 66'(ref_mean(pack4(10, 20, 30, 40), pack4(1, 1, 1, 1))), 66'd25);
                chk("model_wt", 66'(ref_mean(pack4(10, 20, 30, 40), pack4(4, 3, 2, 1))), 66'd20);
                chk("model_trunc", 66'(ref_mean(pack4(1, 2, 0, 0), pack4(1, 1, 0, 0))), 66'd1);
                chk("model_zero", 66'(ref_mean(pack4(5, 6, 7, 8), '0)), 66'hFFFF_FFFF);
                pins_done = 1'b1;
            end
            chk("out_valid", 66'(bus.out_valid), 66'(m_valid));
            chk("busy", 66'(bus.busy), 66'(m_busy));
            chk("in_ready", 66'(bus.in_ready), 66'(!m_busy && enable));
            if (m_valid) begin
                chk("mean", 66'(bus.mean), 66'(m_mean));
                chk("div_zero", 66'(bus.div_zero), 66'(m_dz));
            end
            if (m_rst_seen) begin
                chk("rst_mean", 66'(bus.mean), 66'd0);
                chk("rst_div_zero", 66'(bus.div_zero), 66'd0);
            end
            if (m_valid && !prev_valid && lit_armed) begin
                chk("lit_mean", 66'(bus.mean), 66'(lit_mean));
                chk("lit_div_zero", 66'(bus.div_zero), 66'(lit_dz));
                chk("lit_latency", 66'(cyc - m_t_acc), 66'(lit_lat));
            end
            prev_valid = m_valid;
        end
    end

    // Drives enable/out_ready: random in the random phase, directed otherwise.
    initial begin
        enable = 1'b0;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rand_on) begin
                enable        = ($urandom_range(0, 9) != 0);
                bus.out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                enable        = dir_enable;
                bus.out_ready = dir_out_ready;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic send(input logic [127:0] iv, input logic [127:0] wv);
        int guard;
        guard = 0;
        bus.in       = iv;
        bus.weight   = wv;
        bus.in_valid = 1'b1;
        #0;
        while (!bus.in_ready && guard < 3000) begin
            step();
            guard++;
        end
        if (guard >= 3000) begin
            $display("FAIL send_timeout: in_ready never rose (cycle %0d)", cyc);
            $fatal(1, "bench stopped");
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int guard;
        guard = 0;
        while (!bus.out_valid && guard < 3000) begin
            step();
            guard++;
        end
        if (guard >= 3000) begin
            $display("FAIL out_timeout: out_valid never rose (cycle %0d)", cyc);
            $fatal(1, "bench stopped");
        end
    endtask

    task automatic run_lit(input logic [127:0] iv, input logic [127:0] wv,
                           input logic [31:0] lm, input logic ldz, input int llat);
        lit_mean  = lm;
        lit_dz    = ldz;
        lit_lat   = llat;
        lit_armed = 1'b1;
        send(iv, wv);
        wait_out();
        step();
        step();
        lit_armed = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in       = '0;
        bus.weight   = '0;
        reset        = 1'b1;
        repeat (3) step();
        reset  = 1'b0;
        chk_on = 1'b1;
        step();

        run_lit(pack4(10, 20, 30, 40), pack4(1, 1, 1, 1), 32'd25, 1'b0, 71);
        run_lit(pack4(10, 20, 30, 40), pack4(4, 3, 2, 1), 32'd20, 1'b0, 71);
        run_lit(pack4(1, 2, 0, 0), pack4(1, 1, 0, 0), 32'd1, 1'b0, 71);
        run_lit(pack4(9, 8, 7, 6), '0, 32'hFFFF_FFFF, 1'b1, 5);
        run_lit('1, '1, 32'hFFFF_FFFF, 1'b0, 71);

        // Result held while downstream stalls; a second vector is ignored.
        dir_out_ready = 1'b0;
        step();
        lit_mean  = 32'd25;
        lit_dz    = 1'b0;
        lit_lat   = 71;
        lit_armed = 1'b1;
        send(pack4(10, 20, 30, 40), pack4(1, 1, 1, 1));
        wait_out();
        bus.in       = pack4(100, 100, 100, 100);
        bus.weight   = pack4(1, 1, 1, 1);
        bus.in_valid = 1'b1;
        repeat (10) step();
        bus.in_valid  = 1'b0;
        dir_out_ready = 1'b1;
        repeat (3) step();
        lit_armed = 1'b0;

        // Seven stalled cycles in the middle of the divide.
        lit_mean  = 32'd20;
        lit_dz    = 1'b0;
        lit_lat   = 78;
        lit_armed = 1'b1;
        send(pack4(10, 20, 30, 40), pack4(4, 3, 2, 1));
        repeat (14) step();
        dir_enable = 1'b0;
        repeat (7) step();
        dir_enable = 1'b1;
        wait_out();
        repeat (2) step();
        lit_armed = 1'b0;

        // Reset during the divide, then a clean transaction.
        send(pack4(10, 20, 30, 40), pack4(1, 1, 1, 1));
        repeat (20) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        run_lit(pack4(10, 20, 30, 40), pack4(4, 3, 2, 1), 32'd20, 1'b0, 71);

        // Randomized phase with random enable and downstream back-pressure.
        rand_on = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [127:0] iv;
            logic [127:0] wv;
            int mode;
            mode = $urandom_range(0, 7);
            for (int i = 0; i < N; i++) begin
                iv[i*S +: S] = (mode < 3) ? 32'($urandom_range(0, 1000)) : $urandom;
                wv[i*S +: S] = (mode == 0) ? 32'd0 :
                               (mode < 4) ? 32'($urandom_range(0, 20)) : $urandom;
            end
            send(iv, wv);
        end
        begin
            int guard;
            guard = 0;
            while (bus.busy && guard < 3000) begin
                step();
                guard++;
            end
            if (guard >= 3000) begin
                $display("FAIL drain_timeout: still busy (cycle %0d)", cyc);
                $fatal(1, "bench stopped");
            end
        end
        rand_on = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
